yuyv_frame_writer: RTL and testbench

Capture-side writer for the shared YUYV frame buffer. It takes a clk-synchronous camera byte stream (vsync/href/pixel-valid) and stores one cropped WIDTH x HEIGHT frame as raw YUYV bytes in raster order. It drives the frame buffer's address, data and write-strobe. The block reading that buffer in 8x8 blocks treats mem_wr as a stall, so this block never asserts mem_wr for more than one cycle per byte. On request it captures exactly one frame, then signals completion so the JPEG path can start reading.

---
 rtl/yuyv_frame_writer.sv | 144 ++++++++++++++
 tb/tb_yuyv_frame_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuyv_frame_writer.sv
// Camera-side writer for the shared YUYV frame buffer: captures one cropped
// WIDTH x HEIGHT frame per request and writes its bytes in raster order.
module yuyv_frame_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int BPP    = 2,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_req,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_vld,
    input  logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              mem_wr,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int                RW         = $clog2(HEIGHT + 1);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WIDTH * BPP);
    localparam logic [RW-1:0]     ROWS       = RW'(HEIGHT);

    typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

    state_t            state_reg, state_next;
    logic              href_d_reg, cap_req_d_reg;
    logic [RW-1:0]     row_reg, row_next;
    logic [ADDR_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        data_reg, data_next;
    logic              mem_wr_reg, mem_wr_next;
    logic              busy_reg, busy_next;
    logic              frame_done_reg, frame_done_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            href_d_reg     <= 1'b0;
            cap_req_d_reg  <= 1'b0;
            row_reg        <= '0;
            byte_cnt_reg   <= '0;
            row_base_reg   <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            mem_wr_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            href_d_reg     <= href;
            cap_req_d_reg  <= cap_req;
            row_reg        <= row_next;
            byte_cnt_reg   <= byte_cnt_next;
            row_base_reg   <= row_base_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            mem_wr_reg     <= mem_wr_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        byte_cnt_next   = byte_cnt_reg;
        row_base_next   = row_base_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        mem_wr_next     = 1'b0;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (cap_req && !cap_req_d_reg) begin
                    state_next    = ARM;
                    busy_next     = 1'b1;
                    err_next      = 1'b0;
                    row_next      = '0;
                    byte_cnt_next = '0;
                    row_base_next = '0;
                end
            end
            // Wait for a full vsync pulse so a frame already in flight is skipped.
            ARM: begin
                if (vsync) state_next = SYNC;
            end
            SYNC: begin
                if (!vsync) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (pix_vld && href && (row_reg < ROWS)) begin
                    if (byte_cnt_reg < LINE_BYTES) begin
                        mem_wr_next   = 1'b1;
                        data_next     = pix_data;
                        addr_next     = row_base_reg + byte_cnt_reg;
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                // Line end; an empty href pulse does not consume a row.
                if (href_d_reg && !href && (byte_cnt_reg != '0)) begin
                    if (byte_cnt_reg != LINE_BYTES) err_next = 1'b1;
                    row_next      = row_reg + 1'b1;
                    row_base_next = row_base_reg + LINE_BYTES;
                    byte_cnt_next = '0;
                end
                // Early-end test uses the row count after this cycle's line end.
                if (row_next >= ROWS) begin
                    state_next = DONE;
                end else if (vsync) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            DONE: begin
                frame_done_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign addr       = addr_reg;
    assign data       = data_reg;
    assign mem_wr     = mem_wr_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_yuyv_frame_writer.sv
// Directed bench for yuyv_frame_writer using a 4x3 pixel frame (8-byte lines,
// 24-byte frame) so every scenario stays short.
module tb_yuyv_frame_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int B  = 2;
    localparam int AW = 8;

    logic          clk, reset, cap_req, vsync, href, pix_vld;
    logic [7:0]    pix_data;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          mem_wr, busy, frame_done, err;

    int checks = 0;
    int errors = 0;

    int         wcnt [256];
    logic [7:0] wmem [256];
    int         total, done_cnt, done_cyc, cyc, fall_cyc, f2;
    bit         clr_req;

    yuyv_frame_writer #(.WIDTH(W), .HEIGHT(H), .BPP(B), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cap_req(cap_req), .vsync(vsync),
        .href(href), .pix_vld(pix_vld), .pix_data(pix_data),
        .addr(addr), .data(data), .mem_wr(mem_wr), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every frame-buffer write and frame_done pulse.
    initial begin
        cyc = 0; total = 0; done_cnt = 0; done_cyc = -1;
        for (int a = 0; a < 256; a++) begin wcnt[a] = 0; wmem[a] = 8'h00; end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (clr_req) begin
                for (int a = 0; a < 256; a++) wcnt[a] = 0;
                total = 0; done_cnt = 0; done_cyc = -1;
            end else begin
                if (mem_wr === 1'b1) begin
                    wcnt[addr]++;
                    wmem[addr] = data;
                    total++;
                end
                if (frame_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic cap_pulse();
        cap_req = 1'b1;
        @(negedge clk);
        cap_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line(input int n, input int base, input bit vs_end);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_vld  = 1'b1;
            pix_data = 8'(base + i);
            @(negedge clk);
        end
        pix_vld  = 1'b0;
        href     = 1'b0;
        fall_cyc = cyc;
        if (vs_end) vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Every address below 'last' outside [hole_lo,hole_hi) written once with data == addr.
    task automatic verify(input string tag, input int last, input int hole_lo, input int hole_hi);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            int e;
            e = (a < last && !(a >= hole_lo && a < hole_hi)) ? 1 : 0;
            if (wcnt[a] != e || (e == 1 && wmem[a] !== 8'(a))) bad++;
        end
        check({tag, " bad addresses"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1; cap_req = 1'b0; vsync = 1'b0; href = 1'b0;
        pix_vld = 1'b0; pix_data = 8'h00; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset mem_wr", mem_wr, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset err", err, 0);
        check("reset addr", addr, 0);
        check("reset data", data, 0);
        reset = 1'b0;
        @(negedge clk);
        $display("reset: outputs checked");

        // Full frame plus two surplus lines
        clear_mon();
        cap_pulse();
        check("t1 busy", busy, 1);
        vs_pulse();
        f2 = 0;
        for (int k = 0; k < 5; k++) begin
            send_line(8, k * 8, 1'b0);
            if (k == 2) f2 = fall_cyc;
        end
        check("t1 writes", total, 24);
        verify("t1", 24, 0, 0);
        check("t1 done count", done_cnt, 1);
        check("t1 done timing", done_cyc, f2 + 2);
        check("t1 err", err, 0);
        check("t1 busy end", busy, 0);
        $display("full frame: %0d writes, %0d done pulses", total, done_cnt);

        // Long first line
        clear_mon();
        cap_pulse();
        vs_pulse();
        send_line(12, 0, 1'b0);
        send_line(8, 8, 1'b0);
        send_line(8, 16, 1'b0);
        check("t2 writes", total, 24);
        verify("t2", 24, 0, 0);
        check("t2 err", err, 1);
        check("t2 done count", done_cnt, 1);
        $display("long line: %0d writes, err=%0b", total, err);

        // Short middle line
        clear_mon();
        cap_pulse();
        check("t3 err cleared", err, 0);
        vs_pulse();
        send_line(8, 0, 1'b0);
        send_line(6, 8, 1'b0);
        send_line(8, 16, 1'b0);
        check("t3 writes", total, 22);
        verify("t3", 24, 14, 16);
        check("t3 err", err, 1);
        check("t3 done count", done_cnt, 1);
        $display("short line: %0d writes, err=%0b", total, err);

        // Early vsync after two lines
        clear_mon();
        cap_pulse();
        vs_pulse();
        send_line(8, 0, 1'b0);
        send_line(8, 8, 1'b0);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check("t4 writes", total, 16);
        verify("t4", 16, 0, 0);
        check("t4 err", err, 1);
        check("t4 done count", done_cnt, 1);
        check("t4 busy", busy, 0);
        $display("early vsync: %0d writes, err=%0b", total, err);

        // vsync rising together with the last line's href fall
        clear_mon();
        cap_pulse();
        vs_pulse();
        send_line(8, 0, 1'b0);
        send_line(8, 8, 1'b0);
        send_line(8, 16, 1'b1);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        check("t4b writes", total, 24);
        check("t4b err", err, 0);
        check("t4b done count", done_cnt, 1);
        $display("vsync at last line end: %0d writes, err=%0b", total, err);

        // Request mid-line, re-request while busy, request held high
        clear_mon();
        href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cap_req = 1'b1;
            pix_vld  = 1'b1;
            pix_data = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        pix_vld = 1'b0; href = 1'b0;
        repeat (2) @(negedge clk);
        cap_req = 1'b0;
        @(negedge clk);
        cap_req = 1'b1;
        @(negedge clk);
        vs_pulse();
        for (int k = 0; k < 3; k++) send_line(8, k * 8, 1'b0);
        check("t5 writes", total, 24);
        verify("t5", 24, 0, 0);
        check("t5 done count", done_cnt, 1);
        check("t5 busy", busy, 0);
        vs_pulse();
        for (int k = 0; k < 3; k++) send_line(8, k * 8, 1'b0);
        check("t5 held writes", total, 24);
        check("t5 held done count", done_cnt, 1);
        check("t5 held busy", busy, 0);
        cap_req = 1'b0;
        @(negedge clk);
        $display("request mid-frame/held: %0d writes, %0d done pulses", total, done_cnt);

        // Reset in the middle of a capture
        clear_mon();
        cap_pulse();
        vs_pulse();
        send_line(8, 0, 1'b0);
        href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_vld  = 1'b1;
            pix_data = 8'(8 + i);
            @(negedge clk);
        end
        pix_data = 8'hEE;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("t6 mem_wr after reset", mem_wr, 0);
        check("t6 busy after reset", busy, 0);
        @(negedge clk);
        reset = 1'b0; pix_vld = 1'b0; href = 1'b0;
        repeat (2) @(negedge clk);
        vs_pulse();
        for (int k = 0; k < 3; k++) send_line(8, k * 8, 1'b0);
        check("t6 writes", total, 11);
        verify("t6", 11, 0, 0);
        check("t6 done count", done_cnt, 0);
        check("t6 busy", busy, 0);
        $display("reset mid-capture: %0d writes, busy=%0b", total, busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
